// File: rtl/fp_norm_round_pipe_if.sv
// Handshake and data bundle for the normalise-and-round back end.
// master drives the input beat and out_ready; slave is the pipeline.
interface fp_norm_round_pipe_if #(
    parameter int WIDTH     = 49,
    parameter int WIDTH_mat = 23,
    parameter int WIDTH_exp = 8
);
    logic                           in_valid;
    logic                           in_ready;
    logic                           sign_L;
    logic [WIDTH-1:0]               mat_in;
    logic [WIDTH_exp-1:0]           exp;
    logic [1:0]                     rnd_mode;
    logic                           clear;
    logic                           exce_in;
    logic                           out_valid;
    logic                           out_ready;
    logic [WIDTH_exp+WIDTH_mat:0]   result;
    logic                           exce_out;
    logic [3:0]                     flags;

    modport master (
        output in_valid, sign_L, mat_in, exp, rnd_mode, clear, exce_in, out_ready,
        input  in_ready, out_valid, result, exce_out, flags
    );

    modport slave (
        input  in_valid, sign_L, mat_in, exp, rnd_mode, clear, exce_in, out_ready,
        output in_ready, out_valid, result, exce_out, flags
    );
endinterface

// File: rtl/fp_norm_round_pipe.sv
// Pipelined normalise-and-round back end: leading-zero count, normalising
// shift, round/pack with saturating overflow and flush-to-zero underflow.
// Input sampled at edge N appears on the output register at edge N+3.
module fp_norm_round_pipe #(
    parameter int WIDTH     = 49,
    parameter int WIDTH_mat = 23,
    parameter int WIDTH_exp = 8
) (
    input logic                 CLK,
    input logic                 RST,
    fp_norm_round_pipe_if.slave bus
);
    localparam int LZW   = $clog2(WIDTH + 1);
    localparam int EW    = WIDTH_exp + 2;
    localparam int RW    = 1 + WIDTH_exp + WIDTH_mat;
    localparam int G_BIT = WIDTH - 2 - WIDTH_mat;
    localparam logic signed [EW-1:0] E_INF = EW'((1 << WIDTH_exp) - 1);
    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    // Handshake: a beat transfers on an edge where valid & ready are both 1.
    // The whole pipe moves as one (adv); it freezes only when the output
    // holds a beat that downstream is not taking. in_ready is additionally
    // held low for the first cycle after reset release.
    logic adv, rst_done, out_valid_q;
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv && rst_done;
    assign bus.out_valid = out_valid_q;

    function automatic logic [LZW-1:0] lzc(input logic [WIDTH-1:0] v);
        lzc = LZW'(WIDTH);
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) lzc = LZW'(WIDTH - 1 - i);
    endfunction

    // Raise in_ready one cycle after reset release
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rst_done <= 1'b0;
        else      rst_done <= 1'b1;
    end

    // Stage 1: register operands and their leading-zero count
    logic             s1_valid, s1_sign, s1_clear, s1_exce;
    logic [WIDTH-1:0] s1_man;
    logic [WIDTH_exp-1:0] s1_exp;
    logic [LZW-1:0]   s1_lz;
    logic [1:0]       s1_mode;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid <= 1'b0; s1_sign <= 1'b0; s1_clear <= 1'b0; s1_exce <= 1'b0;
            s1_man <= '0; s1_exp <= '0; s1_lz <= '0; s1_mode <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid && bus.in_ready;
            s1_sign  <= bus.sign_L;
            s1_clear <= bus.clear;
            s1_exce  <= bus.exce_in;
            s1_man   <= bus.mat_in;
            s1_exp   <= bus.exp;
            s1_lz    <= lzc(bus.mat_in);
            s1_mode  <= bus.rnd_mode;
        end
    end

    // Stage 2: normalising shift and unrounded exponent E = exp + 1 - lz
    logic signed [EW-1:0] s1_e_c;
    assign s1_e_c = $signed(EW'(s1_exp) + EW'(1) - EW'(s1_lz));

    logic                 s2_valid, s2_sign, s2_clear, s2_exce;
    logic [WIDTH-1:0]     s2_man;
    logic signed [EW-1:0] s2_e;
    logic [1:0]           s2_mode;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s2_valid <= 1'b0; s2_sign <= 1'b0; s2_clear <= 1'b0; s2_exce <= 1'b0;
            s2_man <= '0; s2_e <= '0; s2_mode <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_clear <= s1_clear;
            s2_exce  <= s1_exce;
            s2_man   <= s1_man << s1_lz;
            s2_e     <= s1_e_c;
            s2_mode  <= s1_mode;
        end
    end

    // Rounding decision from guard, sticky and fraction lsb
    logic [WIDTH_mat-1:0] s2_frac;
    logic                 s2_g, s2_s, s2_inc;
    logic [WIDTH_mat:0]   s2_frac_inc;
    logic signed [EW-1:0] s2_e_rnd;
    assign s2_frac = s2_man[WIDTH-2 -: WIDTH_mat];
    assign s2_g    = s2_man[G_BIT];
    assign s2_s    = |s2_man[G_BIT-1:0];

    // Round increment per rounding mode
    always_comb begin
        s2_inc = 1'b0;
        case (s2_mode)
            RM_RNE: s2_inc = s2_g && (s2_s || s2_frac[0]);
            RM_RTZ: s2_inc = 1'b0;
            RM_RUP: s2_inc = (s2_g || s2_s) && !s2_sign;
            RM_RDN: s2_inc = (s2_g || s2_s) && s2_sign;
            default: s2_inc = 1'b0;
        endcase
    end

    // An all-ones fraction carrying out wraps to zero and bumps the exponent
    assign s2_frac_inc = {1'b0, s2_frac} + (WIDTH_mat + 1)'(s2_inc);
    assign s2_e_rnd    = s2_e + EW'(s2_frac_inc[WIDTH_mat]);

    // Stage 3: register rounded fraction/exponent and classification inputs
    logic                 s3_valid, s3_sign, s3_clear, s3_exce, s3_zero, s3_inexact;
    logic [WIDTH_mat-1:0] s3_frac;
    logic signed [EW-1:0] s3_e;
    logic [1:0]           s3_mode;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s3_valid <= 1'b0; s3_sign <= 1'b0; s3_clear <= 1'b0; s3_exce <= 1'b0;
            s3_zero <= 1'b0; s3_inexact <= 1'b0; s3_frac <= '0; s3_e <= '0; s3_mode <= '0;
        end else if (adv) begin
            s3_valid   <= s2_valid;
            s3_sign    <= s2_sign;
            s3_clear   <= s2_clear;
            s3_exce    <= s2_exce;
            s3_zero    <= !s2_man[WIDTH-1];
            s3_inexact <= s2_g || s2_s;
            s3_frac    <= s2_frac_inc[WIDTH_mat-1:0];
            s3_e       <= s2_e_rnd;
            s3_mode    <= s2_mode;
        end
    end

    // Overflow goes to Inf when rounding direction points away from zero
    logic to_inf;
    assign to_inf = (s3_mode == RM_RNE) || (s3_mode == RM_RUP && !s3_sign) ||
                    (s3_mode == RM_RDN && s3_sign);

    // Pack with exception priority: exce_in, clear, zero, overflow, underflow
    logic [RW-1:0] pk_result;
    logic          pk_exce;
    logic [3:0]    pk_flags;
    always_comb begin
        pk_result = {s3_sign, s3_e[WIDTH_exp-1:0], s3_frac};
        pk_exce   = 1'b0;
        pk_flags  = {2'b00, s3_inexact, 1'b0};
        if (s3_exce) begin
            pk_result = '0;
            pk_exce   = 1'b1;
            pk_flags  = 4'b0000;
        end else if (s3_clear || s3_zero) begin
            pk_result = '0;
            pk_flags  = 4'b0001;
        end else if (s3_e >= E_INF) begin
            pk_exce  = 1'b1;
            pk_flags = 4'b1010;
            pk_result = to_inf ? {s3_sign, {WIDTH_exp{1'b1}}, {WIDTH_mat{1'b0}}}
                               : {s3_sign, {(WIDTH_exp-1){1'b1}}, 1'b0, {WIDTH_mat{1'b1}}};
        end else if (s3_e[EW-1] || s3_e == '0) begin
            pk_result = {s3_sign, {(RW-1){1'b0}}};
            pk_flags  = 4'b0111;
        end
    end

    // Output register: holds its beat while downstream stalls
    logic [RW-1:0] result_q;
    logic          exce_q;
    logic [3:0]    flags_q;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_q <= 1'b0; result_q <= '0; exce_q <= 1'b0; flags_q <= '0;
        end else if (adv) begin
            out_valid_q <= s3_valid;
            result_q    <= pk_result;
            exce_q      <= pk_exce;
            flags_q     <= pk_flags;
        end
    end

    assign bus.result   = result_q;
    assign bus.exce_out = exce_q;
    assign bus.flags    = flags_q;
endmodule
